// File: rtl/rom_pkg.sv
// Shared definitions for the run-time loadable 8x8 lookup table.
package rom_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  // Load FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rom_writer_regfile.sv
// Flop-based table: one write port, one registered read port.
// A read and a write to the same entry on one edge return the old entry.
module rom_writer_regfile
  import rom_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Table entries: cleared on reset, written on we_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read, samples the pre-write contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rom_writer.sv
// Loadable lookup table: a byte stream is written to auto-incrementing
// addresses starting at start_addr, with a registered lookup port.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | waiting for start; write pointer/count latched on start
// LOAD    | accepting bytes, one per cycle while in_valid is high
// DONE    | one-cycle completion pulse, then back to IDLE
module rom_writer
  import rom_pkg::*;
#(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int LEN_W  = rom_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(1 << ADDR_W);

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic [LEN_W-1:0]    rem_q;
  logic [LEN_W-1:0]    wr_count_q;
  logic [LEN_W-1:0]    len_clamped;
  logic                xfer;

  // Longer bursts are clipped so each entry is written at most once
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign xfer        = (state_q == ST_LOAD) && in_valid;
  assign ptr_d       = ptr_q + ADDR_W'(1);

  // Load FSM with write pointer, remaining count and written count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ptr_q      <= start_addr;
            rem_q      <= len_clamped;
            wr_count_q <= '0;
            state_q    <= (len_clamped == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            ptr_q      <= ptr_d;
            rem_q      <= rem_q - LEN_W'(1);
            wr_count_q <= wr_count_q + LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);
  assign wr_count = wr_count_q;

  rom_writer_regfile #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (xfer),
    .waddr_i (ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: doc/rom_writer.md
Name: rom_writer

Overview:
- Writable counterpart to the team's fixed 8x8 lookup ROM: an 8-entry x 8-bit table loaded at run time from a byte stream.
- A load FSM accepts bytes over a valid/ready handshake and writes them to auto-incrementing addresses, starting at a programmable address.
- A registered read port serves lookups to downstream logic that previously used the constant table.

Parameters:
ADDR_W, 3, address width; table depth is 2**ADDR_W (8)
DATA_W, 8, entry width in bits
LEN_W, 4, width of the load-length field (must hold 2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin a load burst
start_addr  in  ADDR_W  first address written in the burst
len  in  LEN_W  number of bytes in the burst
in_valid  in  1  in_data is valid
in_data  in  DATA_W  byte to write
in_ready  out  1  writer accepts in_data this cycle
busy  out  1  burst in progress
done  out  1  one-cycle pulse when a burst completes
wr_count  out  LEN_W  bytes written in the current or last burst
rd_addr  in  ADDR_W  lookup address
rd_data  out  DATA_W  registered lookup data

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - all outputs 0: in_ready, busy, done, wr_count, rd_data.
  - all 8 table entries 0.
  - FSM in IDLE.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1, latch start_addr into the write pointer and min(len, 8) into the remaining count, and clear wr_count.
  - If the latched length is 0, go to DONE; otherwise go to LOAD.
- LOAD:
  - busy=1; in_ready=1 (combinational from state).
  - A transfer occurs when in_valid && in_ready: table[ptr] <= in_data, ptr <= ptr+1 (mod 8), wr_count+1, remaining-1.
  - On the transfer that takes remaining to 0, go to DONE.
  - No transfer means no change; in_valid may idle any number of cycles.
- DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0.
  - Next state is IDLE.
  - wr_count holds its value until the next accepted start.
- start handling:
  - start is ignored in LOAD and DONE; no restart and no error.
  - start in IDLE is sampled only on the clock edge.
- Address wrap: a burst from start_addr=6 with len=4 writes addresses 6, 7, 0, 1.
- len > 8 is clamped to 8, so every entry is written exactly once from start_addr.
- Throughput: 1 byte per cycle when in_valid is held high.
  - Burst latency for N bytes with continuous valid: start edge, then N cycles in LOAD, then the done pulse in the cycle after the last write.
- Read port:
  - rd_data <= table[rd_addr] every cycle, 1-cycle latency.
  - Active in all states.
- Same-cycle write and read to the same address: rd_data returns the old entry (read-before-write); the new value is visible on the following read.
- Reset mid-burst: everything returns to reset values immediately, table cleared, no done pulse.
- Table storage: flop array with async reset, not inferred block RAM, because entries must clear on reset.

Decomposition:
- Shared package (rom_pkg):
  - ADDR_W/DATA_W defaults.
  - FSM state encoding constants (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- Natural sub-module: rom_writer_regfile, the 8x8 flop array with one write port and one registered read port (read-before-write).
- The FSM and pointer/count logic stay in rom_writer.

Test Plan:
- Reset, then read all 8 addresses -> rd_data = 8'h00 for each, one cycle after the address is applied; in_ready=0, busy=0.
- start with start_addr=0, len=8; stream A1,32,C3,14,E5,56,07,18 with valid held high -> done pulses exactly once 1 cycle after the last write, wr_count=8; readback matches the fixed ROM contents.
- start_addr=6, len=4, bytes 11,22,33,44 -> entries 6,7,0,1 = 11,22,33,44; other entries unchanged.
- Burst of len=3 with in_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, in_ready stays 1 throughout LOAD, done after the third accepted byte; len=0 -> done next cycle, no writes, wr_count=0.
- Mid-burst checks:
  - Second start pulse during LOAD -> ignored, burst completes normally.
  - Read of the address being written in the same cycle -> rd_data shows the old value, new value on the next read.
- Assert rst_n low after 2 of 5 bytes -> outputs 0 immediately, table all 0, no done pulse; a new burst then works normally.
